// File: rtl/agc_pkg.sv
// Shared types for the AGC controller family: FSM state encoding, default gain width
// and the counter-width helpers used to size the sequencer's saturating counters.
package agc_pkg;

    localparam int GAIN_W_DEF = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESTART,
        ST_ACQUIRE,
        ST_SETTLE,
        ST_HOLD
    } state_e;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Width that holds 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/agc_seq_timer.sv
// Loadable down-counter shared by all timed sequencer states; it stops at zero and
// flags expiry while it sits there.
module agc_seq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         RESETn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
        else
            cnt_d = cnt_q;
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/agc_sequencer.sv
// Per-packet AGC acquisition sequencer: restart, run, latch, settle, then hold the gain,
// re-acquiring on sustained overload. Define AGC_TRACK_EN for periodic tracking restarts.
module agc_sequencer
    import agc_pkg::*;
#(
    parameter int GAIN_W       = GAIN_W_DEF,
    parameter int RESTART_CYC  = 2,
    parameter int ACQ_TIMEOUT  = 256,
    parameter int SETTLE_CYC   = 8,
    parameter int OVL_THRESH   = 4,
    parameter int MAX_RETRY    = 3,
    parameter int TRACK_PERIOD = 1024
) (
    input  logic              clk,
    input  logic              RESETn,
    input  logic              acq_req,
    input  logic              pkt_end,
    input  logic              overload,
    input  logic [GAIN_W-1:0] agc_gain_in,
    input  logic              agc_done,
    output logic              agc_restart_n,
    output logic              agc_run,
    output logic [GAIN_W-1:0] gain_hold,
    output logic              gain_valid,
    output logic              busy,
    output logic              timeout_err,
    output logic              retry_sat
);

    localparam int TMR_W   = cnt_width(max_of4(RESTART_CYC, ACQ_TIMEOUT, SETTLE_CYC, TRACK_PERIOD));
    localparam int OVL_W   = cnt_width(OVL_THRESH);
    localparam int RETRY_W = cnt_width(MAX_RETRY);

    state_e              state_q, state_d;
    logic [GAIN_W-1:0]   gain_hold_q, gain_hold_d;
    logic [RETRY_W-1:0]  retry_cnt_q, retry_cnt_d;
    logic [OVL_W-1:0]    ovl_cnt_q, ovl_cnt_d;
    logic                timeout_err_q, timeout_err_d;
    logic                retry_sat_q, retry_sat_d;
    logic                agc_restart_n_q, agc_restart_n_d;
    logic                agc_run_q, agc_run_d;
    logic                gain_valid_q, gain_valid_d;
    logic                busy_q, busy_d;

    logic                tmr_load, tmr_expire;
    logic [TMR_W-1:0]    tmr_load_val;
    logic                ovl_trig, track_trig;

    agc_seq_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .RESETn   (RESETn),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .expire   (tmr_expire)
    );

    always_comb begin
        // NOTE: every signal gets a default here so no path through the case infers a latch.
        state_d       = state_q;
        gain_hold_d   = gain_hold_q;
        retry_cnt_d   = retry_cnt_q;
        ovl_cnt_d     = '0;
        timeout_err_d = timeout_err_q;
        retry_sat_d   = retry_sat_q;

        ovl_trig = (state_q == ST_HOLD) && overload && (ovl_cnt_q == OVL_W'(OVL_THRESH - 1));
`ifdef AGC_TRACK_EN
        track_trig = (state_q == ST_HOLD) && tmr_expire;
`else
        track_trig = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (acq_req) begin
                    state_d       = ST_RESTART;
                    retry_cnt_d   = '0;
                    timeout_err_d = 1'b0;
                    retry_sat_d   = 1'b0;
                end
            end
            ST_RESTART: begin
                if (pkt_end)         state_d = ST_IDLE;
                else if (tmr_expire) state_d = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
                if (pkt_end) begin
                    state_d = ST_IDLE;
                end else if (tmr_expire) begin
                    gain_hold_d   = agc_gain_in;
                    timeout_err_d = 1'b1;
                    state_d       = ST_SETTLE;
                end else if (agc_done) begin
                    gain_hold_d = agc_gain_in;
                    state_d     = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (pkt_end)         state_d = ST_IDLE;
                else if (tmr_expire) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (pkt_end) begin
                    state_d = ST_IDLE;
                end else if (ovl_trig) begin
                    // Saturated retries keep the gain frozen; tracking may still restart.
                    if (retry_cnt_q < RETRY_W'(MAX_RETRY)) begin
                        retry_cnt_d = retry_cnt_q + 1'b1;
                        state_d     = ST_RESTART;
                    end else begin
                        retry_sat_d = 1'b1;
                        if (track_trig) state_d = ST_RESTART;
                    end
                end else begin
                    ovl_cnt_d = overload ? ovl_cnt_q + 1'b1 : '0;
                    if (track_trig) state_d = ST_RESTART;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        agc_restart_n_d = (state_d != ST_RESTART);
        agc_run_d       = (state_d == ST_ACQUIRE);
        gain_valid_d    = (state_d == ST_HOLD);
        busy_d          = (state_d != ST_IDLE);

        tmr_load = (state_d != state_q);
        case (state_d)
            ST_RESTART: tmr_load_val = TMR_W'(RESTART_CYC - 1);
            ST_ACQUIRE: tmr_load_val = TMR_W'(ACQ_TIMEOUT - 1);
            ST_SETTLE:  tmr_load_val = TMR_W'(SETTLE_CYC - 1);
            ST_HOLD:    tmr_load_val = TMR_W'(TRACK_PERIOD - 1);
            default:    tmr_load_val = '0;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            state_q         <= ST_IDLE;
            gain_hold_q     <= '0;
            retry_cnt_q     <= '0;
            ovl_cnt_q       <= '0;
            timeout_err_q   <= 1'b0;
            retry_sat_q     <= 1'b0;
            agc_restart_n_q <= 1'b1;
            agc_run_q       <= 1'b0;
            gain_valid_q    <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            gain_hold_q     <= gain_hold_d;
            retry_cnt_q     <= retry_cnt_d;
            ovl_cnt_q       <= ovl_cnt_d;
            timeout_err_q   <= timeout_err_d;
            retry_sat_q     <= retry_sat_d;
            agc_restart_n_q <= agc_restart_n_d;
            agc_run_q       <= agc_run_d;
            gain_valid_q    <= gain_valid_d;
            busy_q          <= busy_d;
        end
    end

    assign agc_restart_n = agc_restart_n_q;
    assign agc_run       = agc_run_q;
    assign gain_hold     = gain_hold_q;
    assign gain_valid    = gain_valid_q;
    assign busy          = busy_q;
    assign timeout_err   = timeout_err_q;
    assign retry_sat     = retry_sat_q;

endmodule

// File: tb/tb_agc_sequencer.sv
// Bench for agc_sequencer: vector table, directed multi-cycle sequences and random
// traffic, all compared every cycle against a phase/age reference model.
module tb_agc_sequencer;

    localparam int GAIN_W       = 6;
    localparam int RESTART_CYC  = 2;
    localparam int ACQ_TIMEOUT  = 256;
    localparam int SETTLE_CYC   = 8;
    localparam int OVL_THRESH   = 4;
    localparam int MAX_RETRY    = 3;
    localparam int TRACK_PERIOD = 1024;

    localparam int P_IDLE = 0, P_RESTART = 1, P_ACQ = 2, P_SETTLE = 3, P_HOLD = 4;

    logic clk = 1'b0;
    logic RESETn;
    logic acq_req, pkt_end, overload, agc_done;
    logic [GAIN_W-1:0] agc_gain_in;
    logic agc_restart_n, agc_run, gain_valid, busy, timeout_err, retry_sat;
    logic [GAIN_W-1:0] gain_hold;

    always #5 clk = ~clk;

    agc_sequencer #(
        .GAIN_W(GAIN_W), .RESTART_CYC(RESTART_CYC), .ACQ_TIMEOUT(ACQ_TIMEOUT),
        .SETTLE_CYC(SETTLE_CYC), .OVL_THRESH(OVL_THRESH), .MAX_RETRY(MAX_RETRY),
        .TRACK_PERIOD(TRACK_PERIOD)
    ) dut (
        .clk(clk), .RESETn(RESETn), .acq_req(acq_req), .pkt_end(pkt_end),
        .overload(overload), .agc_gain_in(agc_gain_in), .agc_done(agc_done),
        .agc_restart_n(agc_restart_n), .agc_run(agc_run), .gain_hold(gain_hold),
        .gain_valid(gain_valid), .busy(busy), .timeout_err(timeout_err),
        .retry_sat(retry_sat)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: which phase we are in and how many cycles we have spent there.
    int              m_phase, m_age, m_ovl, m_retry;
    logic [GAIN_W-1:0] m_gain;
    logic            m_terr, m_rsat;

    task automatic model_reset();
        m_phase = P_IDLE; m_age = 0; m_ovl = 0; m_retry = 0;
        m_gain = '0; m_terr = 1'b0; m_rsat = 1'b0;
    endtask

    task automatic model_enter(input int p);
        m_phase = p; m_age = 0; m_ovl = 0;
    endtask

    task automatic model_step();
        bit go;
        go = 1'b0;
        if (m_phase == P_IDLE) begin
            if (acq_req) begin
                m_retry = 0; m_terr = 1'b0; m_rsat = 1'b0;
                model_enter(P_RESTART);
            end
        end else if (pkt_end) begin
            model_enter(P_IDLE);
        end else begin
            case (m_phase)
                P_RESTART: if (m_age + 1 >= RESTART_CYC) model_enter(P_ACQ); else m_age++;
                P_ACQ: begin
                    if (m_age + 1 >= ACQ_TIMEOUT) begin
                        m_gain = agc_gain_in; m_terr = 1'b1; model_enter(P_SETTLE);
                    end else if (agc_done) begin
                        m_gain = agc_gain_in; model_enter(P_SETTLE);
                    end else m_age++;
                end
                P_SETTLE: if (m_age + 1 >= SETTLE_CYC) model_enter(P_HOLD); else m_age++;
                default: begin
                    m_ovl = overload ? m_ovl + 1 : 0;
                    if (m_ovl >= OVL_THRESH) begin
                        m_ovl = 0;
                        if (m_retry < MAX_RETRY) begin m_retry++; go = 1'b1; end
                        else m_rsat = 1'b1;
                    end
`ifdef AGC_TRACK_EN
                    if (!go && m_age + 1 >= TRACK_PERIOD) go = 1'b1;
`endif
                    if (go) model_enter(P_RESTART); else m_age++;
                end
            endcase
        end
    endtask

    task automatic compare_model();
        check("model_restart_n", agc_restart_n, m_phase != P_RESTART);
        check("model_run",       agc_run,       m_phase == P_ACQ);
        check("model_valid",     gain_valid,    m_phase == P_HOLD);
        check("model_busy",      busy,          m_phase != P_IDLE);
        check("model_gain",      gain_hold,     m_gain);
        check("model_timeout",   timeout_err,   m_terr);
        check("model_retry_sat", retry_sat,     m_rsat);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic drive_idle();
        acq_req = 1'b0; pkt_end = 1'b0; overload = 1'b0; agc_done = 1'b0;
    endtask

    task automatic wait_run(input string name);
        int k;
        k = 0;
        while (agc_run !== 1'b1 && k < 600) begin tick(); k++; end
        check(name, agc_run, 1'b1);
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (gain_valid !== 1'b1 && n < 600) begin tick(); n++; end
        check(name, gain_valid, 1'b1);
    endtask

    typedef struct {
        logic acq, pend, ovl, done;
        logic [GAIN_W-1:0] gain;
        logic e_rstn, e_run, e_valid, e_busy;
        logic [GAIN_W-1:0] e_gain;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int n, lo, restarts, acq_cycles, hold_cycles, low_seen;
        logic prev, done_en, ovl_state;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b1, 6'd0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd9, 1'b1, 1'b1, 1'b0, 1'b1, 6'd0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 1'b1, 1'b0, 1'b0, 1'b1, 6'd5};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'd7, 1'b1, 1'b0, 1'b0, 1'b1, 6'd5};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd7, 1'b1, 1'b0, 1'b0, 1'b0, 6'd5};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd5};

        drive_idle();
        agc_gain_in = '0;
        RESETn = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_restart_n", agc_restart_n, 1'b1);
        check("rst_run",       agc_run,       1'b0);
        check("rst_gain",      gain_hold,     6'd0);
        check("rst_valid",     gain_valid,    1'b0);
        check("rst_busy",      busy,          1'b0);
        check("rst_flags",     {timeout_err, retry_sat}, 2'b00);
        RESETn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            acq_req = vecs[i].acq; pkt_end = vecs[i].pend; overload = vecs[i].ovl;
            agc_done = vecs[i].done; agc_gain_in = vecs[i].gain;
            tick();
            check($sformatf("vec%0d_restart_n", i), agc_restart_n, vecs[i].e_rstn);
            check($sformatf("vec%0d_run", i),       agc_run,       vecs[i].e_run);
            check($sformatf("vec%0d_valid", i),     gain_valid,    vecs[i].e_valid);
            check($sformatf("vec%0d_busy", i),      busy,          vecs[i].e_busy);
            check($sformatf("vec%0d_gain", i),      gain_hold,     vecs[i].e_gain);
        end
        drive_idle();

        // Basic acquisition: done 20 cycles after the request.
        acq_req = 1'b1; tick(); acq_req = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        agc_gain_in = 6'd39; agc_done = 1'b1; tick(); agc_done = 1'b0; agc_gain_in = 6'd0;
        wait_valid("t1_reach_hold", n);
        check("t1_valid_latency", n + 1, SETTLE_CYC + 1);
        check("t1_gain", gain_hold, 6'd39);
        check("t1_timeout", timeout_err, 1'b0);

        // Overload re-acquisition.
        overload = 1'b1;
        repeat (3) tick();
        check("t2_no_early_restart", agc_restart_n, 1'b1);
        tick();
        check("t2_restart_low", agc_restart_n, 1'b0);
        check("t2_valid_drop", gain_valid, 1'b0);
        overload = 1'b0;
        lo = 1;
        repeat (10) begin
            tick();
            if (agc_restart_n === 1'b0) lo++; else break;
        end
        check("t2_restart_len", lo, RESTART_CYC);
        check("t2_run_after_restart", agc_run, 1'b1);
        agc_gain_in = 6'd21; agc_done = 1'b1; tick(); agc_done = 1'b0;
        wait_valid("t2_reach_hold", n);
        check("t2_gain", gain_hold, 6'd21);

        // Acquisition timeout.
        pkt_end = 1'b1; tick(); pkt_end = 1'b0;
        check("t3_idle", busy, 1'b0);
        agc_gain_in = 6'd17;
        acq_req = 1'b1; tick(); acq_req = 1'b0;
        acq_cycles = 0;
        repeat (300) begin tick(); if (agc_run === 1'b1) acq_cycles++; end
        check("t3_acq_cycles", acq_cycles, ACQ_TIMEOUT);
        check("t3_gain", gain_hold, 6'd17);
        check("t3_timeout_set", timeout_err, 1'b1);
        pkt_end = 1'b1; tick(); pkt_end = 1'b0;
        check("t3_timeout_kept", timeout_err, 1'b1);
        acq_req = 1'b1; tick(); acq_req = 1'b0;
        check("t3_timeout_cleared", timeout_err, 1'b0);

        // Permanent overload: bounded retries.
        wait_run("t4_first_run");
        agc_gain_in = 6'd30; agc_done = 1'b1; tick(); agc_done = 1'b0;
        wait_valid("t4_first_hold", n);
        overload = 1'b1; restarts = 0; prev = agc_restart_n;
        repeat (300) begin
            agc_done = agc_run;
            tick();
            if (prev === 1'b1 && agc_restart_n === 1'b0) restarts++;
            prev = agc_restart_n;
        end
        check("t4_restarts", restarts, MAX_RETRY);
        check("t4_retry_sat", retry_sat, 1'b1);
        check("t4_stay_hold", gain_valid, 1'b1);
        drive_idle();

        // pkt_end beats agc_done.
        pkt_end = 1'b1; tick(); pkt_end = 1'b0;
        acq_req = 1'b1; tick(); acq_req = 1'b0;
        wait_run("t5_run");
        agc_gain_in = 6'd50; agc_done = 1'b1; pkt_end = 1'b1; tick(); drive_idle();
        check("t5_idle", busy, 1'b0);
        check("t5_run_off", agc_run, 1'b0);
        check("t5_gain_kept", gain_hold, 6'd30);
        check("t5_valid_off", gain_valid, 1'b0);

        // Asynchronous reset in the middle of an acquisition.
        acq_req = 1'b1; tick(); acq_req = 1'b0;
        repeat (3) tick();
        #2; RESETn = 1'b0; #1;
        model_reset();
        check("arst_run", agc_run, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_gain", gain_hold, 6'd0);
        check("arst_restart_n", agc_restart_n, 1'b1);
        @(negedge clk); RESETn = 1'b1;

        // Tracking restart (or its absence).
        acq_req = 1'b1; tick(); acq_req = 1'b0;
        wait_run("t6_run");
        agc_gain_in = 6'd12; agc_done = 1'b1; tick(); agc_done = 1'b0;
        wait_valid("t6_hold", n);
`ifdef AGC_TRACK_EN
        hold_cycles = 1;
        repeat (1100) begin
            tick();
            if (agc_restart_n === 1'b0) break;
            hold_cycles++;
        end
        check("t6_track_period", hold_cycles, TRACK_PERIOD);
        check("t6_retry_sat", retry_sat, 1'b0);
`else
        low_seen = 0;
        repeat (3000) begin tick(); if (agc_restart_n !== 1'b1) low_seen++; end
        check("t6_no_track_restart", low_seen, 0);
        check("t6_still_hold", gain_valid, 1'b1);
`endif

        // Random traffic against the model.
        done_en = 1'b1; ovl_state = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 199) == 0) done_en = ~done_en;
            if ($urandom_range(0, 9) == 0) ovl_state = ~ovl_state;
            acq_req     = ($urandom_range(0, 19) == 0);
            pkt_end     = ($urandom_range(0, 149) == 0);
            overload    = ovl_state;
            agc_done    = done_en && ($urandom_range(0, 29) == 0);
            agc_gain_in = GAIN_W'($urandom_range(0, 63));
            tick();
        end
        drive_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
